// File: rtl/mux_stream.sv
// Purpose : N-to-1 stream multiplexer with a single registered output stage and per-channel
//           valid/ready handshakes. Selection is manual (force_en/force_sel) or automatic.
// Latency : 1 cycle from input transfer to out_data/out_sel; one word per cycle sustained.
// Backpr. : a grant is issued only when the output register is empty or being drained this
//           cycle (out_ready); otherwise every in_ready is low and all channels stall.
//
// Build option: define MUX_STREAM_RR_EN for round-robin arbitration (search starts after
// the last granted channel). Left undefined, arbitration is fixed priority (lowest index).
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high; drops any held word
//   in_data    CHANNELS*WIDTH packed data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready, at most one bit high
//   force_en   manual-select mode enable
//   force_sel  channel granted while force_en=1 (values >= CHANNELS grant nothing)
//   out_data   registered selected word
//   out_valid  out_data holds an undelivered word
//   out_ready  downstream accept
//   out_sel    source channel of the word in out_data
module mux_stream #(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [SEL_W:0]   CH_COUNT = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(CHANNELS - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [SEL_W-1:0]   last_q,  last_d;

    logic               can_load;
    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic               xfer;
    logic [WIDTH-1:0]   grant_data;
`ifdef MUX_STREAM_RR_EN
    int                 rr_idx;
`endif

    // Grant selection. Depends only on in_valid, out_ready, force_en, force_sel and
    // state, never on in_data, so downstream ready paths stay short.
    always_comb begin
        can_load  = (state_q == EMPTY) | out_ready;
        grant_vld = 1'b0;
        grant_idx = '0;
`ifdef MUX_STREAM_RR_EN
        rr_idx    = 0;
`endif
        if (!reset && can_load) begin
            if (force_en) begin
                // Forced grant is offered even if the channel is not valid; an
                // out-of-range selector grants nothing.
                if ({1'b0, force_sel} < CH_COUNT) begin
                    grant_vld = 1'b1;
                    grant_idx = force_sel;
                end
            end else begin
`ifdef MUX_STREAM_RR_EN
                // Walk channels starting just after the last grant, wrapping at CHANNELS.
                for (int k = 0; k < CHANNELS; k++) begin
                    rr_idx = (int'(last_q) + 1 + k) % CHANNELS;
                    if (!grant_vld && in_valid[rr_idx]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(rr_idx);
                    end
                end
`else
                // Descending scan so the lowest valid index is the one left standing.
                for (int i = CHANNELS - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
`endif
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (grant_vld) begin
            in_ready = CHANNELS'(1) << grant_idx;
        end
    end

    // A transfer needs both sides of the handshake; a forced grant on an idle
    // channel is not a transfer and leaves the pointer alone.
    assign xfer       = grant_vld & in_valid[grant_idx];
    assign grant_data = in_data[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        last_d  = last_q;
        if (xfer) begin
            // Covers the drain-and-refill case too: state stays FULL, no bubble.
            state_d = FULL;
            data_d  = grant_data;
            sel_d   = grant_idx;
            last_d  = grant_idx;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            last_q  <= LAST_RST;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux_stream.sv
// Self-checking bench for mux_stream: directed scenarios followed by random traffic,
// compared every cycle against a behavioural model of the stream contract.
module tb_mux_stream;

    localparam int W  = 4;
    localparam int CH = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [CH*W-1:0]   in_data;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic              force_en;
    logic [SW-1:0]     force_sel;
    logic [W-1:0]      out_data;
    logic              out_valid;
    logic              out_ready;
    logic [SW-1:0]     out_sel;

    int checks   = 0;
    int failures = 0;

    // Model of the visible contract: what the output register holds, and which
    // channel was last actually served.
    bit m_valid;
    int m_data;
    int m_sel;
    int m_last;

    always #5 clk = ~clk;

    mux_stream #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel that should be offered a grant this cycle, or -1 for none.
    function automatic int model_grant();
        int cand;
        if (reset) return -1;
        if (m_valid && !out_ready) return -1;
        if (force_en) return (int'(force_sel) < CH) ? int'(force_sel) : -1;
`ifdef MUX_STREAM_RR_EN
        for (int k = 1; k <= CH; k++) begin
            cand = (m_last + k) % CH;
            if (in_valid[cand]) return cand;
        end
`else
        for (cand = 0; cand < CH; cand++) begin
            if (in_valid[cand]) return cand;
        end
`endif
        return -1;
    endfunction

    function automatic int chan_data(input int c);
        return int'((in_data >> (c * W)) & ((1 << W) - 1));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 0;
        m_sel   = 0;
        m_last  = CH - 1;
    endtask

    // One clock: check outputs mid-cycle, advance the model, then return #1 after
    // the rising edge so callers may sample the post-edge outputs.
    task automatic step(input string tag);
        int g;
        @(negedge clk);
        g = model_grant();
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "_out_data"},  32'(out_data),  32'(m_data));
        chk({tag, "_out_sel"},   32'(out_sel),   32'(m_sel));
        chk({tag, "_in_ready"},  32'(in_ready),  (g >= 0) ? (32'd1 << g) : 32'd0);
        if (reset) begin
            model_reset();
        end else if (g >= 0 && in_valid[g]) begin
            m_valid = 1'b1;
            m_data  = chan_data(g);
            m_sel   = g;
            m_last  = g;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        force_en  = 1'b0;
        force_sel = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset held: in_ready must stay low and outputs cleared.
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) step("rst_hold");

        // Idle: nothing valid for ten cycles.
        reset    = 1'b0;
        in_valid = 4'b0000;
        for (int i = 0; i < 10; i++) step("idle");

        // All channels valid, draining every cycle.
        in_data  = {4'd4, 4'd3, 4'd2, 4'd1};
        in_valid = 4'b1111;
        for (int i = 0; i < 6; i++) step("all_valid");

        // Hold under backpressure, then refill without a bubble.
        reset = 1'b1;
        step("rst2");
        reset    = 1'b0;
        in_data  = {4'd0, 4'd0, 4'd0, 4'hA};
        in_valid = 4'b0001;
        out_ready = 1'b1;
        step("load_a");
        chk("load_a_data", 32'(out_data), 32'hA);
        in_data   = {4'd0, 4'h7, 4'd0, 4'd0};
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall_data", 32'(out_data), 32'hA);
            chk("stall_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        step("refill");
        chk("refill_data", 32'(out_data), 32'h7);
        chk("refill_valid", 32'(out_valid), 32'h1);
        chk("refill_sel", 32'(out_sel), 32'h2);

        // Forced selection, then forced on an idle channel drains the register.
        force_en  = 1'b1;
        force_sel = 2'd3;
        in_data   = {4'h5, 4'h1, 4'h2, 4'h3};
        in_valid  = 4'b1000;
        step("force3");
        chk("force3_data", 32'(out_data), 32'h5);
        chk("force3_sel", 32'(out_sel), 32'h3);
        in_valid = 4'b0111;
        step("force_idle");
        chk("force_idle_valid", 32'(out_valid), 32'h0);
        step("force_idle2");

        // Reset while a word is stalled drops it and restarts the pointer.
        force_en  = 1'b0;
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        step("pre_rst");
        reset = 1'b1;
        step("mid_rst");
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data", 32'(out_data), 32'h0);
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        step("post_rst");
        chk("post_rst_sel", 32'(out_sel), 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            in_data   = 16'($urandom);
            in_valid  = 4'($urandom);
            force_en  = ($urandom_range(0, 4) == 0);
            force_sel = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
